// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice per stage, with a valid/ready handshake.
// The whole pipe freezes while the final result waits for downstream.
module csa_pipe #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTAGE = WIDTH / BLOCK;

   // Returns {carry out, carry into slice MSB, slice sum}.
   function automatic logic [BLOCK+1:0] slice_add(input logic [BLOCK-1:0] x,
                                                  input logic [BLOCK-1:0] y,
                                                  input logic c);
      logic [BLOCK:0] t;
      t = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, c};
      return {t[BLOCK], t[BLOCK-1] ^ x[BLOCK-1] ^ y[BLOCK-1], t[BLOCK-1:0]};
   endfunction

   logic [NSTAGE-1:0] vld_r;
   logic [NSTAGE-1:0] carry_r;
   logic [WIDTH-1:0]  a_r     [NSTAGE];
   logic [WIDTH-1:0]  b_r     [NSTAGE];
   logic [WIDTH-1:0]  sum_r   [NSTAGE];
   logic              ovf_r;

   logic [WIDTH-1:0]  nsum_s  [NSTAGE];
   logic [BLOCK+1:0]  r0_s    [NSTAGE];
   logic [BLOCK+1:0]  r1_s    [NSTAGE];
   logic [BLOCK+1:0]  sel_s   [NSTAGE];
   logic [WIDTH-1:0]  bp_s;
   logic              c0_s;
   logic              stall_s;

   // Stall detection plus both carry hypotheses per slice, selected by the incoming carry.
   always_comb begin
      stall_s   = vld_r[NSTAGE-1] & ~out_ready;
      bp_s      = sub ? ~b : b;
      c0_s      = sub ? 1'b1 : cin;
      r0_s[0]   = slice_add(a[BLOCK-1:0], bp_s[BLOCK-1:0], 1'b0);
      r1_s[0]   = slice_add(a[BLOCK-1:0], bp_s[BLOCK-1:0], 1'b1);
      sel_s[0]  = c0_s ? r1_s[0] : r0_s[0];
      nsum_s[0] = {WIDTH{1'b0}};
      nsum_s[0][BLOCK-1:0] = sel_s[0][BLOCK-1:0];
      for (int k = 1; k < NSTAGE; k++) begin
         r0_s[k]   = slice_add(a_r[k-1][k*BLOCK +: BLOCK], b_r[k-1][k*BLOCK +: BLOCK], 1'b0);
         r1_s[k]   = slice_add(a_r[k-1][k*BLOCK +: BLOCK], b_r[k-1][k*BLOCK +: BLOCK], 1'b1);
         sel_s[k]  = carry_r[k-1] ? r1_s[k] : r0_s[k];
         nsum_s[k] = sum_r[k-1];
         nsum_s[k][k*BLOCK +: BLOCK] = sel_s[k][BLOCK-1:0];
      end
   end

   // Stage registers: advance together when not stalled, hold everything otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_r   <= {NSTAGE{1'b0}};
         carry_r <= {NSTAGE{1'b0}};
         ovf_r   <= 1'b0;
         for (int k = 0; k < NSTAGE; k++) begin
            a_r[k]   <= {WIDTH{1'b0}};
            b_r[k]   <= {WIDTH{1'b0}};
            sum_r[k] <= {WIDTH{1'b0}};
         end
      end else if (!stall_s) begin
         vld_r[0]   <= in_valid;
         a_r[0]     <= a;
         b_r[0]     <= bp_s;
         sum_r[0]   <= nsum_s[0];
         carry_r[0] <= sel_s[0][BLOCK+1];
         for (int k = 1; k < NSTAGE; k++) begin
            vld_r[k]   <= vld_r[k-1];
            a_r[k]     <= a_r[k-1];
            b_r[k]     <= b_r[k-1];
            sum_r[k]   <= nsum_s[k];
            carry_r[k] <= sel_s[k][BLOCK+1];
         end
         ovf_r <= sel_s[NSTAGE-1][BLOCK+1] ^ sel_s[NSTAGE-1][BLOCK];
      end
   end

   assign in_ready  = ~stall_s;
   assign out_valid = vld_r[NSTAGE-1];
   assign sum       = sum_r[NSTAGE-1];
   assign cout      = carry_r[NSTAGE-1];
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_csa_pipe.sv
// Scoreboard bench for csa_pipe (WIDTH=16, BLOCK=4): expected results queued at input acceptance,
// popped and compared by an independent output monitor.
module tb_csa_pipe;

   localparam int NST = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   csa_pipe #(.WIDTH(16), .BLOCK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
      int          acyc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          pushed = 0;
   int          popped = 0;
   int          discarded = 0;
   bit          chk_lat = 1'b0;
   bit          rdy_mode = 1'b0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_sum = 16'h0000;

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's meaning.
   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic c, input logic s);
      exp_t e;
      int   ux = int'(x);
      int   uy = int'(y);
      int   sx = int'($signed(x));
      int   sy = int'($signed(y));
      int   r;
      int   u;
      if (s) begin
         u    = ux - uy;
         e.co = (ux >= uy);
         r    = sx - sy;
      end else begin
         u    = ux + uy + int'(c);
         e.co = (u > 65535);
         r    = sx + sy + int'(c);
      end
      e.s    = u[15:0];
      e.ov   = (r > 32767) || (r < -32768);
      e.acyc = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   // Monitor: handshake rules, stall stability, and scoreboard push/pop, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         bit   stall;
         stall = out_valid && !out_ready;
         check("in_ready_rule", {31'd0, in_ready}, {31'd0, !stall});
         if (prev_stall) begin
            check("stall_sum_hold", {16'd0, sum}, {16'd0, prev_sum});
            check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
         end
         if (in_valid && in_ready) begin
            e      = model(a, b, cin, sub);
            e.acyc = cyc;
            e.lat  = chk_lat;
            sb.push_back(e);
            pushed++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_result: got sum 0x%0h expected no result at cycle %0d", sum, cyc);
            end else begin
               e = sb.pop_front();
               popped++;
               check("sum", {16'd0, sum}, {16'd0, e.s});
               check("cout", {31'd0, cout}, {31'd0, e.co});
               check("ovf", {31'd0, ovf}, {31'd0, e.ov});
               if (e.lat) check("latency", cyc - e.acyc, NST);
            end
         end
         prev_stall = stall;
         prev_sum   = sum;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Random backpressure while rdy_mode is set.
   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) out_ready = 1'($urandom_range(0, 1));
   end

   // Called #1 after a rising edge; returns #1 after the edge that accepted the operation.
   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
      bit acc;
      int n;
      in_valid = 1'b1;
      a = x; b = y; cin = c; sub = s;
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      int p0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed single operations with latency checks.
      chk_lat = 1'b1;
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0); idle(); drain();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); idle(); drain();
      issue(16'h7FFF, 16'h0000, 1'b1, 1'b0); idle(); drain();
      issue(16'h0005, 16'h0007, 1'b1, 1'b1); idle(); drain();
      issue(16'h8000, 16'h0001, 1'b0, 1'b1); idle(); drain();
      chk_lat = 1'b0;

      // Alternating add/sub stream under random backpressure.
      rdy_mode = 1'b1;
      for (int i = 0; i < 40; i++)
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'(i % 2));
      idle();
      rdy_mode = 1'b0;
      out_ready = 1'b1;
      drain();

      // Fill the pipe with downstream blocked, hold, then release.
      out_ready = 1'b0;
      for (int i = 0; i < NST; i++)
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      idle();
      repeat (5) @(posedge clk);
      #1;
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      p0 = popped;
      out_ready = 1'b1;
      repeat (NST) @(negedge clk);
      @(posedge clk);
      #1;
      check("drain_consecutive", popped - p0, NST);
      drain();

      // Asynchronous reset with operations in flight.
      for (int i = 0; i < 3; i++)
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      idle();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_sum", {16'd0, sum}, 32'd0);
      discarded += sb.size();
      sb.delete();
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_lat = 1'b1;
      issue(16'h1234, 16'h4321, 1'b1, 1'b0); idle(); drain();
      chk_lat = 1'b0;

      check("no_loss", popped, pushed - discarded);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
